control_pipeline: RTL and testbench

Carries the decoded control bundles from the instruction decoder (ID stage) through the EX, MEM and WB pipeline registers.
- Each stage receives exactly the control fields it consumes.
- Inserts bubbles on stall and raises the IF/ID flush request on a taken branch.
- Keeps a saturating bubble counter.
- Sits between the decoder and the datapath stage registers.

---
 rtl/control_pipeline_pkg.sv | 49 ++++
 rtl/control_pipeline_if.sv | 58 +++++
 rtl/control_pipeline_stage_reg.sv | 36 +++
 rtl/control_pipeline.sv | 101 ++++++++++
 tb/tb_control_pipeline.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/control_pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared widths, bit positions and bubble constants for the
//                decoded control bundles carried by control_pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  localparam int WB_CTRL_W   = 2;
  localparam int MEM_CTRL_W  = 2;
  localparam int CALC_CTRL_W = 4;

  // writeBackControl = {regWrite, memToReg}
  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;
  // memAccessControl = {memRead, memWrite}
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 0;
  // calculationControl = {regDst, aluOp1, aluOp0, aluSrc}
  localparam int REGDST_BIT   = 3;
  localparam int ALUOP1_BIT   = 2;
  localparam int ALUOP0_BIT   = 1;
  localparam int ALUSRC_BIT   = 0;

  localparam logic [WB_CTRL_W-1:0]   WB_BUBBLE   = '0;
  localparam logic [MEM_CTRL_W-1:0]  MEM_BUBBLE  = '0;
  localparam logic [CALC_CTRL_W-1:0] CALC_BUBBLE = '0;

  // Write enables must be a solid 1 to count; X/Z from an unknown opcode
  // collapses to 0 so it can never turn into a register write.
  function automatic logic [WB_CTRL_W-1:0] sanitiseWb(input logic [WB_CTRL_W-1:0] wb);
    logic [WB_CTRL_W-1:0] res;
    res = wb;
    res[REGWRITE_BIT] = (wb[REGWRITE_BIT] === 1'b1);
    return res;
  endfunction

  // Both memory strobes are side-effecting, so both are sanitised.
  function automatic logic [MEM_CTRL_W-1:0] sanitiseMem(input logic [MEM_CTRL_W-1:0] mem);
    logic [MEM_CTRL_W-1:0] res;
    res = mem;
    res[MEMREAD_BIT]  = (mem[MEMREAD_BIT] === 1'b1);
    res[MEMWRITE_BIT] = (mem[MEMWRITE_BIT] === 1'b1);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_pipeline_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipeline_if
//  Description : Decoder-side inputs and stage-register outputs of the
//                control pipeline. master = decoder/datapath, slave = pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_pipeline_if #(
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int BUBBLE_COUNT_WIDTH = 16
);
  import ctrl_pkg::*;

  // ID stage
  logic                          idValid;
  logic [WB_CTRL_W-1:0]          writeBackControl;
  logic [MEM_CTRL_W-1:0]         memAccessControl;
  logic [CALC_CTRL_W-1:0]        calculationControl;
  logic                          branch;
  logic                          stallIn;
  logic [REG_ADDR_WIDTH-1:0]     idRs;
  logic [REG_ADDR_WIDTH-1:0]     idRt;
  // EX stage
  logic                          exValid;
  logic [WB_CTRL_W-1:0]          exWriteBackControl;
  logic [MEM_CTRL_W-1:0]         exMemAccessControl;
  logic [CALC_CTRL_W-1:0]        exCalculationControl;
  logic [REG_ADDR_WIDTH-1:0]     exRt;
  // MEM stage
  logic                          memValid;
  logic [WB_CTRL_W-1:0]          memWriteBackControl;
  logic [MEM_CTRL_W-1:0]         memMemAccessControl;
  // WB stage
  logic                          wbValid;
  logic [WB_CTRL_W-1:0]          wbWriteBackControl;
  // Control back to IF/ID
  logic                          stallOut;
  logic                          flushId;
  logic [BUBBLE_COUNT_WIDTH-1:0] bubbleCount;

  modport master (
    output idValid, writeBackControl, memAccessControl, calculationControl,
           branch, stallIn, idRs, idRt,
    input  exValid, exWriteBackControl, exMemAccessControl, exCalculationControl,
           exRt, memValid, memWriteBackControl, memMemAccessControl,
           wbValid, wbWriteBackControl, stallOut, flushId, bubbleCount
  );

  modport slave (
    input  idValid, writeBackControl, memAccessControl, calculationControl,
           branch, stallIn, idRs, idRt,
    output exValid, exWriteBackControl, exMemAccessControl, exCalculationControl,
           exRt, memValid, memWriteBackControl, memMemAccessControl,
           wbValid, wbWriteBackControl, stallOut, flushId, bubbleCount
  );

endinterface
`default_nettype wire

// File: rtl/control_pipeline_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_stage_reg
//  Description : One pipeline stage register: payload plus valid bit, with
//                async reset and a bubble-load select. An invalid input is
//                stored as an all-zero payload so no stale control leaks on.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_stage_reg #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             loadBubble,
  input  wire logic             validIn,
  input  wire logic [WIDTH-1:0] dataIn,
  output logic                  validOut,
  output logic [WIDTH-1:0]      dataOut
);

  // Capture the upstream bundle, or zeros on bubble / empty slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validOut <= 1'b0;
      dataOut  <= '0;
    end else if (loadBubble || !validIn) begin
      validOut <= 1'b0;
      dataOut  <= '0;
    end else begin
      validOut <= 1'b1;
      dataOut  <= dataIn;
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipeline
//  Description : Carries decoded control bundles ID -> EX -> MEM -> WB,
//                inserts bubbles on stall, requests IF/ID flush on a taken
//                branch and counts inserted bubbles (saturating).
//                Optional load-use hazard stall: define CTRL_PIPE_HAZARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_pipeline #(
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int BUBBLE_COUNT_WIDTH = 16
) (
  input wire logic          clk,
  input wire logic          reset,
  control_pipeline_if.slave bus
);
  import ctrl_pkg::*;

  localparam int EX_W  = WB_CTRL_W + MEM_CTRL_W + CALC_CTRL_W + REG_ADDR_WIDTH;
  localparam int MEM_W = WB_CTRL_W + MEM_CTRL_W;
  localparam int WB_W  = WB_CTRL_W;

  logic                          wHazard;
  logic                          wStall;
  logic [EX_W-1:0]               wExIn;
  logic [EX_W-1:0]               wExOut;
  logic [MEM_W-1:0]              wMemOut;
  logic [WB_W-1:0]               wWbOut;
  logic [BUBBLE_COUNT_WIDTH-1:0] rBubbleCount;

`ifdef CTRL_PIPE_HAZARD_EN
  // Load in EX whose destination feeds the ID instruction: hold for one
  // cycle. The bubble clears exValid, so the stall self-terminates.
  assign wHazard = bus.exValid & bus.exMemAccessControl[MEMREAD_BIT] & bus.idValid &
                   ((bus.exRt == bus.idRs) | (bus.exRt == bus.idRt));
`else
  logic [REG_ADDR_WIDTH-1:0] unusedIdRs;
  assign unusedIdRs = bus.idRs;
  assign wHazard    = 1'b0;
`endif

  assign wStall       = bus.stallIn | wHazard;
  assign bus.stallOut = wStall;
  // A stall holds IF/ID, so a branch waits and re-evaluates afterwards.
  assign bus.flushId  = bus.branch & bus.idValid & ~wStall;

  assign wExIn = {sanitiseWb(bus.writeBackControl), sanitiseMem(bus.memAccessControl),
                  bus.calculationControl, bus.idRt};

  ctrl_stage_reg #(.WIDTH(EX_W)) uExStage (
    .clk        (clk),
    .reset      (reset),
    .loadBubble (wStall),
    .validIn    (bus.idValid),
    .dataIn     (wExIn),
    .validOut   (bus.exValid),
    .dataOut    (wExOut)
  );

  assign {bus.exWriteBackControl, bus.exMemAccessControl,
          bus.exCalculationControl, bus.exRt} = wExOut;

  // Downstream stages always advance, a stall only affects EX.
  ctrl_stage_reg #(.WIDTH(MEM_W)) uMemStage (
    .clk        (clk),
    .reset      (reset),
    .loadBubble (1'b0),
    .validIn    (bus.exValid),
    .dataIn     ({bus.exWriteBackControl, bus.exMemAccessControl}),
    .validOut   (bus.memValid),
    .dataOut    (wMemOut)
  );

  assign {bus.memWriteBackControl, bus.memMemAccessControl} = wMemOut;

  ctrl_stage_reg #(.WIDTH(WB_W)) uWbStage (
    .clk        (clk),
    .reset      (reset),
    .loadBubble (1'b0),
    .validIn    (bus.memValid),
    .dataIn     (bus.memWriteBackControl),
    .validOut   (bus.wbValid),
    .dataOut    (wWbOut)
  );

  assign bus.wbWriteBackControl = wWbOut;

  // Count bubbles that displaced a real instruction; stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rBubbleCount <= '0;
    end else if (wStall && bus.idValid && (rBubbleCount != '1)) begin
      rBubbleCount <= rBubbleCount + BUBBLE_COUNT_WIDTH'(1);
    end
  end

  assign bus.bubbleCount = rBubbleCount;

endmodule
`default_nettype wire

// File: tb/tb_control_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_pipeline
//  Description : Self-checking bench for control_pipeline: directed cases
//                followed by random traffic against a slot-list model.
//  Revision    : 1.1 - checking task replaces comparison macro
// ============================================================================
module tb_control_pipeline;

    localparam int RA  = 5;
    localparam int BCW = 2;

    typedef struct packed {
        logic          v;
        logic [1:0]    wb;
        logic [1:0]    mem;
        logic [3:0]    calc;
        logic [RA-1:0] rt;
    } slot_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    slot_t          mEx, mMem, mWb;
    int             mCount;
    localparam int  CMAX = (1 << BCW) - 1;

    control_pipeline_if #(.REG_ADDR_WIDTH(RA), .BUBBLE_COUNT_WIDTH(BCW)) bus ();

    control_pipeline #(.REG_ADDR_WIDTH(RA), .BUBBLE_COUNT_WIDTH(BCW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, string name, logic [63:0] obs, logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    function automatic logic modelHazard();
`ifdef CTRL_PIPE_HAZARD_EN
        return mEx.v && mEx.mem[1] && (bus.idValid === 1'b1) &&
               ((mEx.rt == bus.idRs) || (mEx.rt == bus.idRt));
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        mEx = '0; mMem = '0; mWb = '0; mCount = 0;
    endtask

    task automatic checkRegs(string tag);
        chk(tag, "exValid",  bus.exValid, mEx.v);
        chk(tag, "exWb",     bus.exWriteBackControl, mEx.wb);
        chk(tag, "exMem",    bus.exMemAccessControl, mEx.mem);
        chk(tag, "exCalc",   bus.exCalculationControl, mEx.calc);
        chk(tag, "exRt",     bus.exRt, mEx.rt);
        chk(tag, "memValid", bus.memValid, mMem.v);
        chk(tag, "memWb",    bus.memWriteBackControl, mMem.wb);
        chk(tag, "memMem",   bus.memMemAccessControl, mMem.mem);
        chk(tag, "wbValid",  bus.wbValid, mWb.v);
        chk(tag, "wbWb",     bus.wbWriteBackControl, mWb.wb);
        chk(tag, "bubbles",  bus.bubbleCount, mCount);
    endtask

    task automatic step(string tag);
        logic  stall, flush;
        slot_t nx;
        @(negedge clk);
        stall = bus.stallIn | modelHazard();
        flush = bus.branch & bus.idValid & ~stall;
        chk(tag, "stallOut", bus.stallOut, stall);
        chk(tag, "flushId",  bus.flushId, flush);
        nx = '0;
        if (!stall && bus.idValid === 1'b1) begin
            nx.v    = 1'b1;
            nx.wb   = {bus.writeBackControl[1] === 1'b1, bus.writeBackControl[0]};
            nx.mem  = {bus.memAccessControl[1] === 1'b1, bus.memAccessControl[0] === 1'b1};
            nx.calc = bus.calculationControl;
            nx.rt   = bus.idRt;
        end
        if (stall && bus.idValid === 1'b1 && mCount < CMAX) mCount++;
        mWb  = '0; mWb.v = mMem.v; mWb.wb = mMem.wb;
        mMem = '0; mMem.v = mEx.v; mMem.wb = mEx.wb; mMem.mem = mEx.mem;
        mEx  = nx;
        @(posedge clk);
        #1;
        checkRegs(tag);
    endtask

    task automatic drive(logic v, logic [1:0] wb, logic [1:0] mem, logic [3:0] calc,
                         logic br, logic st, logic [RA-1:0] rs, logic [RA-1:0] rt);
        bus.idValid = v; bus.writeBackControl = wb; bus.memAccessControl = mem;
        bus.calculationControl = calc; bus.branch = br; bus.stallIn = st;
        bus.idRs = rs; bus.idRt = rt;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        modelReset();
        drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("reset");
        reset = 1'b0;

        drive(1'b1, 2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd1, 5'd2);
        step("rfmt1");
        chk("rfmt1", "exCalcConst", bus.exCalculationControl, 4'b1100);
        drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, '0, '0);
        step("rfmt2");
        chk("rfmt2", "memWbConst", bus.memWriteBackControl, 2'b10);
        step("rfmt3");
        chk("rfmt3", "wbWbConst", bus.wbWriteBackControl, 2'b10);
        chk("rfmt3", "wbValidConst", bus.wbValid, 1'b1);

        drive(1'b1, 2'bxx, 2'bxx, 4'b0000, 1'b0, 1'b0, '0, '0);
        step("xop1");
        chk("xop1", "exRegWrite", bus.exWriteBackControl[1], 1'b0);
        chk("xop1", "exMemConst", bus.exMemAccessControl, 2'b00);
        drive(1'b0, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, '0, '0);
        step("xop2");
        step("xop3");
        chk("xop3", "wbRegWrite", bus.wbWriteBackControl[1], 1'b0);

        drive(1'b1, 2'b11, 2'b10, 4'b0001, 1'b0, 1'b0, 5'd3, 5'd4);
        step("fill1");
        drive(1'b1, 2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd6, 5'd7);
        step("fill2");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 2'b01, 4'b0011, 1'b0, 1'b1, 5'd8, 5'd9);
            step("stall");
            chk("stall", "exValidConst", bus.exValid, 1'b0);
        end
        chk("stall", "countConst", bus.bubbleCount, 3);
        step("sat");
        chk("sat", "countHold", bus.bubbleCount, 3);

        drive(1'b1, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0, 5'd1, 5'd2);
        #1;
        chk("branch", "flushConst", bus.flushId, 1'b1);
        step("branch");
        drive(1'b1, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b1, 5'd1, 5'd2);
        #1;
        chk("brstall", "flushConst", bus.flushId, 1'b0);
        step("brstall");

        drive(1'b1, 2'b11, 2'b10, 4'b0001, 1'b0, 1'b0, 5'd0, 5'd5);
        step("load");
        drive(1'b1, 2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd5, 5'd0);
        step("use1");
        step("use2");
        step("use3");

        drive(1'b1, 2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 5'd10, 5'd11);
        step("full1");
        step("full2");
        step("full3");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkRegs("asyncRst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("postRst");

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0),
                  RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
